// File: rtl/regfile_dump_if.sv
// ---------------------------------------------------------------------------
// regfile_dump_if
//  Bundles the control, regfile read-port and output-stream signals of the
//  register-file dump engine.
//
//  Modports
//   slave  : the dump engine (regfile_dump)
//   master : the surrounding environment (debug controller, regfile read
//            port, downstream sink)
//
//  Signals
//   Start, Abort       control requests into the engine
//   StartReg, EndReg   inclusive index range, latched on an accepted Start
//   ReadReg / ReadData combinational regfile read port
//   OutReg, OutData,   output beat with valid/ready handshake
//   OutValid, OutReady
//   Busy, Done         status
//   Checksum           only when REGDUMP_CHECKSUM_EN is defined
// ---------------------------------------------------------------------------
interface regfile_dump_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              Start;
    logic              Abort;
    logic [ADDR_W-1:0] StartReg;
    logic [ADDR_W-1:0] EndReg;
    logic [ADDR_W-1:0] ReadReg;
    logic [DATA_W-1:0] ReadData;
    logic [ADDR_W-1:0] OutReg;
    logic [DATA_W-1:0] OutData;
    logic              OutValid;
    logic              OutReady;
    logic              Busy;
    logic              Done;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] Checksum;
`endif

    modport slave (
        input  Start,
        input  Abort,
        input  StartReg,
        input  EndReg,
        output ReadReg,
        input  ReadData,
        output OutReg,
        output OutData,
        output OutValid,
        input  OutReady,
        output Busy,
        output Done
`ifdef REGDUMP_CHECKSUM_EN
        , output Checksum
`endif
    );

    modport master (
        output Start,
        output Abort,
        output StartReg,
        output EndReg,
        input  ReadReg,
        output ReadData,
        input  OutReg,
        input  OutData,
        input  OutValid,
        output OutReady,
        input  Busy,
        input  Done
`ifdef REGDUMP_CHECKSUM_EN
        , input Checksum
`endif
    );
endinterface

// File: rtl/regfile_dump.sv
// ---------------------------------------------------------------------------
// regfile_dump
//  Sequential reader for the 32x32 register file. Walks an inclusive register
//  index range through one combinational regfile read port and streams each
//  {index, value} pair out on a valid/ready interface. Used by debug/trace
//  logic to snapshot architectural state. r0 is never emitted: a start index
//  of 0 is clamped to 1.
//
//  Ports
//   CLK   in  clock, all state updates on the rising edge
//   clrn  in  asynchronous active-high reset
//   bus   regfile_dump_if.slave:
//           Start/Abort/StartReg/EndReg  control and range
//           ReadReg -> / ReadData <-     regfile read port (ReadReg = cur)
//           OutReg/OutData/OutValid/OutReady  output stream
//           Busy (READ/HOLD), Done (one-cycle end pulse)
//           Checksum (REGDUMP_CHECKSUM_EN only)
//
//  Configuration
//   REGDUMP_CHECKSUM_EN  when defined, adds an XOR accumulator over every
//                        accepted beat; cleared on accepted Start, held after
//                        Done until the next accepted Start.
//
//  Timing: Start sampled at edge E0 -> READ; first OutValid after E1. Each
//  beat costs READ + at least one HOLD cycle, so one beat per 2 cycles max.
//  Done rises the cycle after FIN, so an empty range also reports after E1.
// ---------------------------------------------------------------------------
module regfile_dump #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic           CLK,
    input  logic           clrn,
    regfile_dump_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cur_q;
    logic [ADDR_W-1:0] end_q;
    logic [ADDR_W-1:0] out_reg_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              busy_q;
    logic              done_q;

    logic [ADDR_W-1:0] start_cur_d;
    logic [ADDR_W-1:0] cur_next_d;
    logic              range_empty_d;
    logic              handshake_d;
    logic              last_beat_d;

`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    function automatic logic [DATA_W-1:0] csum_fold(
        input logic [DATA_W-1:0] acc,
        input logic [DATA_W-1:0] data
    );
        return acc ^ data;
    endfunction
`endif

    // Clamp start index, classify the requested range and decode the handshake.
    always_comb begin
        start_cur_d = bus.StartReg;
        if (bus.StartReg == {ADDR_W{1'b0}}) begin
            start_cur_d = {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            start_cur_d = bus.StartReg;
        end
        range_empty_d = (start_cur_d > bus.EndReg);
        handshake_d   = out_valid_q && bus.OutReady;
        // Compared before incrementing, so end=31 never lets cur wrap to 0.
        last_beat_d   = (cur_q == end_q);
        cur_next_d    = cur_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end

    // Dump FSM with all outputs registered; Abort overrides every state.
    always_ff @(posedge CLK or posedge clrn) begin
        if (clrn) begin
            state_q     <= ST_IDLE;
            cur_q       <= {ADDR_W{1'b0}};
            end_q       <= {ADDR_W{1'b0}};
            out_reg_q   <= {ADDR_W{1'b0}};
            out_data_q  <= {DATA_W{1'b0}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum_q      <= {DATA_W{1'b0}};
`endif
        end else if (bus.Abort) begin
            // Partial beat is dropped and no Done is reported.
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.Start) begin
                        cur_q <= start_cur_d;
                        end_q <= bus.EndReg;
`ifdef REGDUMP_CHECKSUM_EN
                        csum_q <= {DATA_W{1'b0}};
`endif
                        if (range_empty_d) begin
                            state_q <= ST_FIN;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_READ;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_READ: begin
                    // ReadData is the combinational regfile value at cur_q.
                    out_data_q  <= bus.ReadData;
                    out_reg_q   <= cur_q;
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b1;
                    state_q     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (handshake_d) begin
                        out_valid_q <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
                        csum_q <= csum_fold(csum_q, out_data_q);
`endif
                        if (last_beat_d) begin
                            state_q <= ST_FIN;
                            busy_q  <= 1'b0;
                        end else begin
                            cur_q   <= cur_next_d;
                            state_q <= ST_READ;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_HOLD;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ReadReg  = cur_q;
    assign bus.OutReg   = out_reg_q;
    assign bus.OutData  = out_data_q;
    assign bus.OutValid = out_valid_q;
    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
`ifdef REGDUMP_CHECKSUM_EN
    assign bus.Checksum = csum_q;
`endif

endmodule
